// File: rtl/cpu_bus_arbiter_pkg.sv
// Shared types and constants for the CPU instruction/data bus arbiter.
// The optional wait-state timeout is enabled by defining ARB_TIMEOUT_EN.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } arb_state_t;

  localparam logic MASTER_I = 1'b0;
  localparam logic MASTER_D = 1'b1;

  // Read data returned to the owner when a wait is abandoned.
  localparam logic [31:0] TIMEOUT_RDATA = 32'h0;

  // Everything needed to replay a held data request onto the memory port.
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [3:0]  be;
    logic [31:0] wdata;
  } d_slot_t;

endpackage

// File: rtl/cpu_bus_arbiter_if.sv
// Bundle of the CPU-side and memory-side signals around the arbiter.
// slave  : the arbiter's view (takes CPU requests, drives the memory port).
// master : the surrounding system's view (CPU buses plus memory together).
interface cpu_bus_arbiter_if;
  import cpu_bus_pkg::*;

  logic        cpui_request;
  logic [31:0] cpui_addr;
  logic [31:0] cpui_rdata;
  logic        cpui_ack;

  logic        cpud_request;
  logic [31:0] cpud_addr;
  logic        cpud_write;
  logic [3:0]  cpud_byte_enable;
  logic [31:0] cpud_wdata;
  logic [31:0] cpud_rdata;
  logic        cpud_ack;

  logic        mem_request;
  logic [31:0] mem_addr;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        mem_master;
  logic        timeout_error;

  modport slave (
    input  cpui_request, cpui_addr,
    output cpui_rdata, cpui_ack,
    input  cpud_request, cpud_addr, cpud_write, cpud_byte_enable, cpud_wdata,
    output cpud_rdata, cpud_ack,
    output mem_request, mem_addr, mem_write, mem_byte_enable, mem_wdata,
    input  mem_rdata, mem_ack,
    output mem_master, timeout_error
  );

  modport master (
    output cpui_request, cpui_addr,
    input  cpui_rdata, cpui_ack,
    output cpud_request, cpud_addr, cpud_write, cpud_byte_enable, cpud_wdata,
    input  cpud_rdata, cpud_ack,
    input  mem_request, mem_addr, mem_write, mem_byte_enable, mem_wdata,
    output mem_rdata, mem_ack,
    input  mem_master, timeout_error
  );

endinterface

// File: rtl/cpu_bus_arbiter_slot.sv
// Single-entry holding register for a request that could not launch at once.
module cpu_bus_slot
  import cpu_bus_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         pending
);

  // Payload is only meaningful while pending, so it is captured without reset.
  always_ff @(posedge clock) begin
    if (load) dout <= din;
  end

  // Pending flag: set on load, dropped when the held request is granted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     pending <= 1'b0;
    else if (load)  pending <= 1'b1;
    else if (clear) pending <= 1'b0;
  end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Arbiter sharing one memory port between the CPU instruction and data buses.
// Data normally wins; the instruction side is guaranteed a grant after
// MAX_D_BURST consecutive data grants. Define ARB_TIMEOUT_EN to abandon a
// wait after TIMEOUT_CYCLES cycles with a forced acknowledge.
module cpu_bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int MAX_D_BURST    = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic              clock,
  input logic              reset,
  cpu_bus_arbiter_if.slave bus
);

  localparam int            BW        = $clog2(MAX_D_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_D_BURST);

  if (MAX_D_BURST < 1) begin : g_bad_burst
    $error("cpu_bus_arbiter: MAX_D_BURST must be at least 1");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("cpu_bus_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_t    state;
  logic [BW-1:0] burst_cnt;
  logic          in_wait, done, tmo_hit, can_launch, launch;
  logic          i_pend, d_pend, i_busy, d_busy, i_drop, d_drop;
  logic          i_req_ok, d_req_ok, i_cand, d_cand, grant_i, grant_d;
  logic          i_load, d_load;
  logic [31:0]   i_held, i_src;
  d_slot_t       d_live, d_held, d_src;

  assign in_wait = (state != IDLE);
  assign done    = in_wait && (bus.mem_ack || tmo_hit);

  // A master is busy while its slot holds a request or its transaction has
  // not yet completed; a request in the completing cycle is accepted.
  assign i_busy   = i_pend || (state == WAIT_I && !done);
  assign d_busy   = d_pend || (state == WAIT_D && !done);
  assign i_drop   = bus.cpui_request && i_busy;
  assign d_drop   = bus.cpud_request && d_busy;
  assign i_req_ok = bus.cpui_request && !i_busy;
  assign d_req_ok = bus.cpud_request && !d_busy;
  assign i_cand   = i_pend || i_req_ok;
  assign d_cand   = d_pend || d_req_ok;

  assign can_launch = (state == IDLE) || done;
  assign grant_i    = can_launch && i_cand && (!d_cand || burst_cnt == BURST_MAX);
  assign grant_d    = can_launch && d_cand && !grant_i;
  assign launch     = grant_i || grant_d;

  assign i_load = i_req_ok && !grant_i;
  assign d_load = d_req_ok && !grant_d;

  assign d_live = {bus.cpud_addr, bus.cpud_write, bus.cpud_byte_enable, bus.cpud_wdata};
  assign i_src  = i_pend ? i_held : bus.cpui_addr;
  assign d_src  = d_pend ? d_held : d_live;

  cpu_bus_slot #(.W(32)) u_slot_i (
    .clock   (clock),
    .reset   (reset),
    .load    (i_load),
    .clear   (grant_i),
    .din     (bus.cpui_addr),
    .dout    (i_held),
    .pending (i_pend)
  );

  cpu_bus_slot #(.W($bits(d_slot_t))) u_slot_d (
    .clock   (clock),
    .reset   (reset),
    .load    (d_load),
    .clear   (grant_d),
    .din     (d_live),
    .dout    (d_held),
    .pending (d_pend)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = in_wait && !bus.mem_ack && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Count unacknowledged wait cycles since the current launch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                      tmo_cnt <= '0;
    else if (launch)                 tmo_cnt <= '0;
    else if (in_wait && !bus.mem_ack) tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Grant FSM: launches one transaction and holds the memory fields until ack.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state               <= IDLE;
      bus.mem_request     <= 1'b0;
      bus.mem_addr        <= '0;
      bus.mem_write       <= 1'b0;
      bus.mem_byte_enable <= '0;
      bus.mem_wdata       <= '0;
      bus.mem_master      <= MASTER_I;
    end else begin
      bus.mem_request <= launch;
      if (grant_d) begin
        state               <= WAIT_D;
        bus.mem_addr        <= d_src.addr;
        bus.mem_write       <= d_src.write;
        bus.mem_byte_enable <= d_src.be;
        bus.mem_wdata       <= d_src.wdata;
        bus.mem_master      <= MASTER_D;
      end else if (grant_i) begin
        state               <= WAIT_I;
        bus.mem_addr        <= i_src;
        bus.mem_write       <= 1'b0;
        bus.mem_byte_enable <= 4'hF;
        bus.mem_wdata       <= '0;
        bus.mem_master      <= MASTER_I;
      end else if (done) begin
        state <= IDLE;
      end
    end
  end

  // Track consecutive data grants made while an instruction request waits.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                burst_cnt <= '0;
    else if (grant_i || !i_cand)               burst_cnt <= '0;
    else if (grant_d && burst_cnt != BURST_MAX) burst_cnt <= burst_cnt + 1'b1;
  end

  assign bus.cpui_ack      = (state == WAIT_I) && done;
  assign bus.cpud_ack      = (state == WAIT_D) && done;
  assign bus.cpui_rdata    = tmo_hit ? TIMEOUT_RDATA : bus.mem_rdata;
  assign bus.cpud_rdata    = tmo_hit ? TIMEOUT_RDATA : bus.mem_rdata;
  assign bus.timeout_error = tmo_hit;

  // Flag a request from a master that already has one outstanding; it is dropped.
  always @(posedge clock) begin
    if (reset) begin
      assert (!i_drop) else $warning("cpu_bus_arbiter: cpui_request dropped, instruction transaction outstanding");
      assert (!d_drop) else $warning("cpu_bus_arbiter: cpud_request dropped, data transaction outstanding");
    end
  end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Self-checking bench for cpu_bus_arbiter: directed scenarios followed by
// random traffic, all compared against a transaction-level reference model.
// Build with ARB_TIMEOUT_EN defined to include the timeout scenario.
module tb_cpu_bus_arbiter;
  import cpu_bus_pkg::*;

  localparam int MAXB = 4;
  localparam int TMO  = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  cpu_bus_arbiter_if bus();

  cpu_bus_arbiter #(.MAX_D_BURST(MAXB), .TIMEOUT_CYCLES(TMO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the port, what waits, and the D grant history.
  int          cyc = 0;
  int          own = 0;          // 0 none, 1 instruction, 2 data
  int          age = 0;          // wait cycles without ack since launch
  bit          iw = 0;
  logic [31:0] iw_addr = '0;
  int          iw_since = 0;
  bit          dw = 0;
  logic [31:0] dw_addr = '0;
  logic        dw_we = 1'b0;
  logic [3:0]  dw_be = '0;
  logic [31:0] dw_wd = '0;
  int          dgrant_t[$];
  logic        e_req = 1'b0, e_we = 1'b0, e_master = 1'b0;
  logic [31:0] e_addr = '0, e_wd = '0;
  logic [3:0]  e_be = '0;

  logic        obs_iack, obs_dack, obs_terr, obs_idrop;
  logic [31:0] obs_irdata, obs_drdata;
  int          i_launches = 0;
  logic        seq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.cpui_request = 0; bus.cpui_addr = '0;
    bus.cpud_request = 0; bus.cpud_addr = '0; bus.cpud_write = 0;
    bus.cpud_byte_enable = '0; bus.cpud_wdata = '0;
    bus.mem_ack = 0; bus.mem_rdata = '0;
  endtask

  task automatic model_reset();
    own = 0; age = 0; iw = 0; dw = 0; dgrant_t.delete();
    e_req = 0; e_we = 0; e_master = 0; e_addr = '0; e_wd = '0; e_be = '0;
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    #1;
    chk("rst_mem_request", bus.mem_request, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_write", bus.mem_write, 0);
    chk("rst_mem_byte_enable", bus.mem_byte_enable, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_mem_master", bus.mem_master, 0);
    chk("rst_cpui_ack", bus.cpui_ack, 0);
    chk("rst_cpud_ack", bus.cpud_ack, 0);
    chk("rst_timeout_error", bus.timeout_error, 0);
    model_reset();
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b1;
  endtask

  // One clock cycle: inputs already driven; check against the model, advance.
  task automatic step();
    bit forced, done, i_ok, d_ok, free, gi, gd;
    int streak;
    #3;
    forced = 0;
`ifdef ARB_TIMEOUT_EN
    forced = (own != 0) && !bus.mem_ack && (age == TMO - 1);
`endif
    done = (own != 0) && (bus.mem_ack || forced);
    obs_iack = bus.cpui_ack;     obs_dack = bus.cpud_ack;
    obs_irdata = bus.cpui_rdata; obs_drdata = bus.cpud_rdata;
    obs_terr = bus.timeout_error; obs_idrop = dut.i_drop;
    if (bus.mem_request === 1'b1 && bus.mem_master === MASTER_I) i_launches++;

    chk("mem_request", bus.mem_request, e_req);
    chk("mem_master", bus.mem_master, e_master);
    chk("mem_addr", bus.mem_addr, e_addr);
    chk("mem_write", bus.mem_write, e_we);
    chk("mem_byte_enable", bus.mem_byte_enable, e_be);
    if (e_master == MASTER_D) chk("mem_wdata", bus.mem_wdata, e_wd);
    chk("cpui_ack", bus.cpui_ack, (own == 1) && done);
    chk("cpud_ack", bus.cpud_ack, (own == 2) && done);
    chk("cpui_rdata", bus.cpui_rdata, forced ? 32'h0 : bus.mem_rdata);
    chk("cpud_rdata", bus.cpud_rdata, forced ? 32'h0 : bus.mem_rdata);
    chk("timeout_error", bus.timeout_error, forced);

    i_ok = bus.cpui_request && !iw && !(own == 1 && !done);
    d_ok = bus.cpud_request && !dw && !(own == 2 && !done);
    chk("i_drop", dut.i_drop, bus.cpui_request && !i_ok);
    chk("d_drop", dut.d_drop, bus.cpud_request && !d_ok);

    if (i_ok) begin iw = 1; iw_addr = bus.cpui_addr; iw_since = cyc; end
    if (d_ok) begin
      dw = 1; dw_addr = bus.cpud_addr; dw_we = bus.cpud_write;
      dw_be = bus.cpud_byte_enable; dw_wd = bus.cpud_wdata;
    end

    // Data grants made since the instruction request started waiting.
    streak = 0;
    foreach (dgrant_t[k]) if (dgrant_t[k] >= iw_since) streak++;
    free = (own == 0) || done;
    gd = free && dw && !(iw && streak >= MAXB);
    gi = free && iw && !gd;

    e_req = gi || gd;
    if (gd) begin
      e_addr = dw_addr; e_we = dw_we; e_be = dw_be; e_wd = dw_wd; e_master = 1;
      own = 2; age = 0; dw = 0; dgrant_t.push_back(cyc);
    end else if (gi) begin
      e_addr = iw_addr; e_we = 0; e_be = 4'hF; e_master = 0;
      own = 1; age = 0; iw = 0;
    end else if (done) begin
      own = 0;
    end else if (own != 0) begin
      age++;
    end

    @(posedge clock); #1;
    cyc++;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    #1;
    do_reset();

    // Single instruction read, memory acks two cycles after the request.
    bus.cpui_request = 1; bus.cpui_addr = 32'h100; step();
    chk("t1_req_next_cycle", bus.mem_request, 1);
    chk("t1_addr", bus.mem_addr, 32'h100);
    chk("t1_master", bus.mem_master, 0);
    chk("t1_be", bus.mem_byte_enable, 4'hF);
    step();
    bus.mem_ack = 1; bus.mem_rdata = 32'h12345678; step();
    chk("t1_iack", obs_iack, 1);
    chk("t1_irdata", obs_irdata, 32'h12345678);
    chk("t1_dack", obs_dack, 0);
    step();

    // Simultaneous requests: data first, instruction right at data's ack.
    bus.cpui_request = 1; bus.cpui_addr = 32'h300;
    bus.cpud_request = 1; bus.cpud_addr = 32'h200; bus.cpud_write = 1;
    bus.cpud_byte_enable = 4'b0011; bus.cpud_wdata = 32'hCAFEF00D; step();
    chk("t2_d_master", bus.mem_master, 1);
    chk("t2_d_addr", bus.mem_addr, 32'h200);
    chk("t2_d_write", bus.mem_write, 1);
    chk("t2_d_be", bus.mem_byte_enable, 4'b0011);
    chk("t2_d_wdata", bus.mem_wdata, 32'hCAFEF00D);
    step();
    bus.mem_ack = 1; step();
    chk("t2_dack", obs_dack, 1);
    chk("t2_i_no_bubble", bus.mem_request, 1);
    chk("t2_i_master", bus.mem_master, 0);
    chk("t2_i_addr", bus.mem_addr, 32'h300);
    bus.mem_ack = 1; bus.mem_rdata = 32'h0BADF00D; step();
    chk("t2_iack", obs_iack, 1);
    step();

    // Instruction waiting behind a continuous data stream.
    seq.delete();
    bus.cpui_request = 1; bus.cpui_addr = 32'h400;
    bus.cpud_request = 1; bus.cpud_addr = 32'h500; step();
    seq.push_back(bus.mem_master);
    for (int k = 0; k < 4; k++) begin
      bus.cpud_request = 1; bus.cpud_addr = 32'h600 + k; bus.mem_ack = 1; step();
      seq.push_back(bus.mem_master);
    end
    bus.mem_ack = 1; step();
    seq.push_back(bus.mem_master);
    chk("t3_grants", seq.size(), 6);
    for (int k = 0; k < 6; k++) chk($sformatf("t3_grant%0d", k), seq[k], (k == 4) ? 0 : 1);
    bus.mem_ack = 1; step();
    step();

    // Reset in the middle of a data wait; the late ack must be ignored.
    bus.cpud_request = 1; bus.cpud_addr = 32'h700; step();
    step();
    step();
    do_reset();
    bus.mem_ack = 1; bus.mem_rdata = 32'hDEADBEEF; step();
    chk("t4_stale_dack", obs_dack, 0);
    chk("t4_stale_iack", obs_iack, 0);
    chk("t4_no_req", bus.mem_request, 0);

    // Second instruction request while the first is in flight.
    i_launches = 0;
    bus.cpui_request = 1; bus.cpui_addr = 32'h800; step();
    bus.cpui_request = 1; bus.cpui_addr = 32'h900; step();
    chk("t6_drop_flag", obs_idrop, 1);
    bus.mem_ack = 1; step();
    chk("t6_iack", obs_iack, 1);
    step(); step();
    chk("t6_single_launch", i_launches, 1);

`ifdef ARB_TIMEOUT_EN
    // Memory never acks a data read; forced ack after the timeout.
    bus.cpud_request = 1; bus.cpud_addr = 32'hA00; step();
    for (int k = 1; k <= TMO; k++) begin
      if (k == 1) begin bus.cpui_request = 1; bus.cpui_addr = 32'hB00; end
      bus.mem_rdata = 32'h5555AAAA;
      step();
      if (k < TMO) chk("t5_early_dack", obs_dack, 0);
    end
    chk("t5_dack", obs_dack, 1);
    chk("t5_terr", obs_terr, 1);
    chk("t5_rdata", obs_drdata, 32'h0);
    chk("t5_i_launch", bus.mem_request, 1);
    chk("t5_i_master", bus.mem_master, 0);
    chk("t5_i_addr", bus.mem_addr, 32'hB00);
    bus.mem_ack = 1; step();
    step();
`endif

    // Random traffic under protocol-respecting masters.
    for (int n = 0; n < 400; n++) begin
      if (!(iw || own == 1) && $urandom_range(0, 3) == 0) begin
        bus.cpui_request = 1; bus.cpui_addr = $urandom;
      end
      if (!(dw || own == 2) && $urandom_range(0, 2) == 0) begin
        bus.cpud_request = 1; bus.cpud_addr = $urandom;
        bus.cpud_write = 1'($urandom_range(0, 1));
        bus.cpud_byte_enable = 4'($urandom_range(0, 15));
        bus.cpud_wdata = $urandom;
      end
      bus.mem_ack = ($urandom_range(0, 3) == 0);
      bus.mem_rdata = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
